mult_scheduler: RTL

MULT_SCHEDULER -- requirements
Module: mult_scheduler

---
 rtl/mult_scheduler_pkg.sv | 28 ++
 rtl/mult_scheduler_rr_arbiter2.sv | 33 +++
 rtl/mult_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mult_scheduler_pkg.sv
// Shared types for the multiplier scheduler: operand packet, response
// word and controller state encoding.
package mult_scheduler_pkg;

    typedef struct packed {
        logic signed [15:0] arg_a;
        logic               arg_a_parity;
        logic signed [15:0] arg_b;
        logic               arg_b_parity;
    } rq_pkt_t;

    typedef struct packed {
        logic signed [31:0] mult_res;
        logic               par_error;
        logic               result_par;
        logic               timeout;
    } rsp_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    localparam int TO_CNT_W = 10;

endpackage

// File: rtl/mult_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; priority flips to the other requester
// whenever a grant is taken with en_i high.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o  = req_i;
        prio_d = prio_q;
        if (req_i == 2'b11) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
        end
        if (en_i && (gnt_o != 2'b00)) begin
            prio_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one external multiplier between two requesters, one op at a time.
// Define MULT_SCHEDULER_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES.
module mult_scheduler
    import mult_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    rq_valid,
    output logic [1:0]    rq_ready,
    input  rq_pkt_t [1:0] rq_data,
    output logic [1:0]    rsp_valid,
    input  logic [1:0]    rsp_ready,
    output rsp_t [1:0]    rsp_data,
    output logic          mul_req,
    output logic [15:0]   mul_arg_a,
    output logic [15:0]   mul_arg_b,
    output logic          mul_arg_a_parity,
    output logic          mul_arg_b_parity,
    input  logic          mul_ack,
    input  logic [31:0]   mul_result,
    input  logic          mul_result_parity,
    input  logic          mul_arg_parity_error,
    input  logic          mul_result_rdy
);

    state_e  state_q, state_d;
    rq_pkt_t pkt_q, pkt_d;
    logic    id_q, id_d;
    rsp_t    rsp_q, rsp_d;
    rsp_t    res_in;
    logic [1:0] arb_req;
    logic [1:0] gnt;
    logic       arb_en;

`ifdef MULT_SCHEDULER_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign res_in = '{
        mult_res:   mul_result,
        par_error:  mul_arg_parity_error,
        result_par: mul_result_parity,
        timeout:    1'b0
    };

    // Requests only reach the arbiter while idle and out of reset
    assign arb_req = (state_q == IDLE && rst_n) ? rq_valid : 2'b00;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (arb_req),
        .en_i  (arb_en),
        .gnt_o (gnt)
    );

    assign mul_arg_a        = pkt_q.arg_a;
    assign mul_arg_b        = pkt_q.arg_b;
    assign mul_arg_a_parity = pkt_q.arg_a_parity;
    assign mul_arg_b_parity = pkt_q.arg_b_parity;

    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        id_d      = id_q;
        rsp_d     = rsp_q;
        rq_ready  = 2'b00;
        rsp_valid = 2'b00;
        rsp_data  = '0;
        mul_req   = 1'b0;
        arb_en    = 1'b0;
`ifdef MULT_SCHEDULER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (arb_req != 2'b00) begin
                    rq_ready = gnt;
                    arb_en   = 1'b1;
                    id_d     = gnt[1];
                    pkt_d    = rq_data[gnt[1]];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                mul_req = 1'b1;
                if (mul_ack) begin
                    if (mul_result_rdy) begin
                        rsp_d   = res_in;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
`ifdef MULT_SCHEDULER_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            WAIT: begin
                if (mul_result_rdy) begin
                    rsp_d   = res_in;
                    state_d = RESP;
                end
`ifdef MULT_SCHEDULER_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    rsp_d   = '{mult_res: '0, par_error: 1'b0,
                                result_par: 1'b0, timeout: 1'b1};
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                rsp_valid[id_q] = 1'b1;
                rsp_data[id_q]  = rsp_q;
                if (rsp_ready[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pkt_q   <= '0;
            id_q    <= 1'b0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            id_q    <= id_d;
            rsp_q   <= rsp_d;
        end
    end

`ifdef MULT_SCHEDULER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule
